// File: rtl/myproject_dense_accum.sv
// Accumulates N_TERMS unsigned products, adds a bias, shifts, and presents one result per frame.
// Optional unsigned output saturation is enabled by defining MYPROJECT_ACCUM_SAT_EN.
module myproject_dense_accum #(
    parameter int unsigned PROD_WIDTH = 9,
    parameter int unsigned N_TERMS    = 16,
    parameter int unsigned BIAS       = 0,
    parameter int unsigned SHIFT      = 4,
    parameter int unsigned OUT_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    output logic [OUT_WIDTH-1:0]  res_tdata,
    output logic                  res_tvalid,
    input  logic                  res_tready
);

    localparam int unsigned ACC_WIDTH = PROD_WIDTH + $clog2(N_TERMS);
    localparam int unsigned TOT_WIDTH = ACC_WIDTH + 1;
    localparam int unsigned EXT_WIDTH = (TOT_WIDTH > OUT_WIDTH) ? TOT_WIDTH : OUT_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(N_TERMS);

    localparam logic [ACC_WIDTH-1:0] BiasVal  = ACC_WIDTH'(BIAS);
    localparam logic [CNT_WIDTH-1:0] LastCnt  = CNT_WIDTH'(N_TERMS - 1);
    localparam logic [OUT_WIDTH-1:0] OutMax   = {OUT_WIDTH{1'b1}};

    typedef enum logic [0:0] {StAccum, StDone} state_e;

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [OUT_WIDTH-1:0]   res_q, res_d;

    logic                   accept;
    logic [ACC_WIDTH-1:0]   sum_next;
    logic [TOT_WIDTH-1:0]   total;
    logic [EXT_WIDTH-1:0]   scaled;
    logic [OUT_WIDTH-1:0]   result;

    // Handshake outputs come straight from the state register.
    assign prod_tready = (state_q == StAccum);
    assign res_tvalid  = (state_q == StDone);
    assign res_tdata   = res_q;

    assign accept   = prod_tvalid && (state_q == StAccum);
    assign sum_next = acc_q + ACC_WIDTH'(prod_tdata);
    assign total    = {1'b0, sum_next} + {1'b0, BiasVal};
    assign scaled   = EXT_WIDTH'(total >> SHIFT);

`ifdef MYPROJECT_ACCUM_SAT_EN
    assign result = (scaled > EXT_WIDTH'(OutMax)) ? OutMax : scaled[OUT_WIDTH-1:0];
`else
    assign result = scaled[OUT_WIDTH-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        res_d   = res_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d   = sum_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LastCnt) begin
                        res_d   = result;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (res_tready) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            count_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: doc/myproject_dense_accum.md
MYPROJECT_DENSE_ACCUM -- requirements
Module: myproject_dense_accum

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 9: width of each unsigned product from the upstream multiplier.
REQ-002 SHALL have parameter N_TERMS, default 16, legal range 2..256: number of products summed per result.
REQ-003 SHALL have parameter BIAS, default 0: unsigned bias added once per result; width ACC_WIDTH.
REQ-004 SHALL have parameter SHIFT, default 4, legal range 0..ACC_WIDTH: right shift applied after the bias add.
REQ-005 SHALL have parameter OUT_WIDTH, default 8: result width.
REQ-006 SHALL derive localparam ACC_WIDTH = PROD_WIDTH + clog2(N_TERMS), which is 13 at defaults.
REQ-007 SHALL have port ap_clk, input, width 1: single clock; all state updates on the rising edge.
REQ-008 SHALL have port ap_rst, input, width 1: asynchronous, active-high reset.
REQ-009 SHALL have port prod_tdata, input, width PROD_WIDTH: unsigned product.
REQ-010 SHALL have port prod_tvalid, input, width 1: product valid.
REQ-011 SHALL have port prod_tready, output, width 1: product accepted when prod_tvalid and prod_tready are both high.
REQ-012 SHALL have port res_tdata, output, width OUT_WIDTH: result.
REQ-013 SHALL have port res_tvalid, output, width 1: result valid.
REQ-014 SHALL have port res_tready, input, width 1: downstream ready.

Function
REQ-015 SHALL implement a two-state FSM:
- ACCUM: prod_tready=1, res_tvalid=0.
- DONE: prod_tready=0, res_tvalid=1.
REQ-016 In ACCUM, each accepted product SHALL update acc <= acc + prod_tdata and count <= count + 1; acc is unsigned, ACC_WIDTH bits, and never wraps for legal parameters.
REQ-017 prod_tvalid low in ACCUM SHALL leave acc and count unchanged, with no timeout.
REQ-018 Acceptance of the N_TERMS-th product SHALL register res_tdata from the final sum and move the FSM to DONE.
- Result valid on the next rising edge: latency 1 cycle after the last accepted product.
REQ-019 Result arithmetic:
- total = final sum + BIAS, computed at ACC_WIDTH+1 bits with no overflow.
- scaled = total >> SHIFT (logical shift).
- scaled is then reduced to OUT_WIDTH per REQ-027/REQ-028.
REQ-020 In DONE, res_tdata and res_tvalid SHALL hold stable until res_tready is sampled high.
REQ-021 On the DONE cycle with res_tready=1, the FSM SHALL return to ACCUM and clear acc and count to 0.
- The next product is accepted on the following cycle.
- Throughput is N_TERMS+1 cycles per result with no stalls.
REQ-022 res_tready high while in ACCUM SHALL have no effect.
REQ-023 res_tvalid SHALL NOT depend combinationally on res_tready.
- Both prod_tready and res_tvalid SHALL be decoded from registered state only.

Reset
REQ-024 ap_rst high SHALL immediately, without waiting for a clock edge, force:
- FSM to ACCUM; acc, count and res_tdata to 0; res_tvalid to 0.
- prod_tready to 1 once ap_rst is released.
REQ-025 ap_rst mid-frame SHALL discard any partial sum; the first product accepted after release starts a new frame.
REQ-026 ap_rst asserted in DONE SHALL drop the pending result, which is never presented downstream.

Configuration
REQ-027 With macro MYPROJECT_ACCUM_SAT_EN defined, res_tdata SHALL be min(scaled, 2^OUT_WIDTH-1), i.e. unsigned saturation.
REQ-028 Without MYPROJECT_ACCUM_SAT_EN, res_tdata SHALL be scaled[OUT_WIDTH-1:0], i.e. truncation with wrap.
- Port list, latency and handshake are identical in both builds.

Verification
REQ-029 Basic frame, defaults with BIAS=8: products 1..16 back-to-back -> res_tvalid one cycle after the 16th accept, res_tdata=9 ((136+8)>>4), both builds.
REQ-030 Saturation, BIAS=0: sixteen products of 300 -> sum 4800, scaled 300 -> res_tdata=255 with MYPROJECT_ACCUM_SAT_EN, 44 without.
REQ-031 Backpressure: hold res_tready=0 for 5 cycles after result 9 appears -> res_tdata stays 9, prod_tready stays 0; with res_tready=1 -> prod_tready=1 on the next cycle, acc=0.
REQ-032 Gaps: products of 16 with prod_tvalid toggling every other cycle -> exactly 16 accepts, res_tdata=16 (256>>4), latency still 1 cycle after the last accept.
REQ-033 Reset mid-frame: 7 products of 100, then pulse ap_rst, then sixteen products of 16 -> single result 16; no result emitted for the aborted frame.
REQ-034 Reset in DONE: assert ap_rst while res_tvalid=1 and res_tready=0 -> res_tvalid falls asynchronously, the result is never transferred, and the next frame computes correctly.
